// File: rtl/chan_ctrl_pkg.sv
// Shared definitions for the channelizer reconfiguration sequencer:
// state encodings, FFT size limits and the size -> {legal, log2} helper.
package chan_ctrl_pkg;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_CONFIG = 2'd1,
        S_RUN    = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    localparam int FFT_MIN    = 8;
    localparam int FFT_MAX    = 2048;
    localparam int NFFT_WIDTH = 5;
    localparam int NFFT_MIN   = $clog2(FFT_MIN);
    localparam int NFFT_MAX   = $clog2(FFT_MAX);

    // Returns {legal, nfft}; legal only for a single set bit in [NFFT_MIN..NFFT_MAX].
    function automatic logic [NFFT_WIDTH:0] fft_nfft(input logic [15:0] size);
        logic [NFFT_WIDTH:0] r;
        r = '0;
        for (int i = NFFT_MIN; i <= NFFT_MAX; i++) begin
            if (size == (16'd1 << i)) begin
                r = {1'b1, i[NFFT_WIDTH-1:0]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_size_decode.sv
// Combinational legality check and log2 of a requested FFT size.
module fft_size_decode
    import chan_ctrl_pkg::*;
#(
    parameter int FFT_SIZE_WIDTH = 12
) (
    input  logic [FFT_SIZE_WIDTH-1:0] size,
    output logic                      legal,
    output logic                      illegal,
    output logic [NFFT_WIDTH-1:0]     nfft
);

    logic [NFFT_WIDTH:0] dec;

    assign dec     = fft_nfft(16'(size));
    assign legal   = dec[NFFT_WIDTH];
    assign nfft    = dec[NFFT_WIDTH-1:0];
    // Zero means "no request" and is neither legal nor an error.
    assign illegal = (size != '0) && !dec[NFFT_WIDTH];

endmodule

// File: rtl/chan_reconfig_ctrl.sv
// Sequencer for the channelizer datapath: drains the in-flight frame on an fft_size
// change, resets the chain, configures the xfft, then reopens the input gate.
module chan_reconfig_ctrl
    import chan_ctrl_pkg::*;
#(
    parameter int FFT_SIZE_WIDTH   = 12,
    parameter int DEFAULT_FFT_SIZE = 128,
    parameter int RESET_CYCLES     = 8,
    parameter int DRAIN_TIMEOUT    = 4096
) (
    input  logic                      clk,
    input  logic                      sync_reset,
    input  logic [FFT_SIZE_WIDTH-1:0] fft_size_req,
    input  logic                      frame_done,
    output logic                      gate_en,
    output logic                      chan_reset,
    output logic                      fft_aresetn,
    output logic                      fft_config_tvalid,
    output logic [15:0]               fft_config_tdata,
    input  logic                      fft_config_tready,
    output logic [FFT_SIZE_WIDTH-1:0] fft_size_active,
    output logic                      busy,
    output logic                      cfg_error,
    output logic                      drain_timeout
);

    localparam logic [NFFT_WIDTH:0]         DEFAULT_DEC  = fft_nfft(16'(DEFAULT_FFT_SIZE));
    localparam logic [FFT_SIZE_WIDTH-1:0]   DEFAULT_SIZE = FFT_SIZE_WIDTH'(DEFAULT_FFT_SIZE);
    localparam logic [4:0]                  RST_LOAD     = 5'(RESET_CYCLES - 1);
    localparam logic [15:0]                 DRAIN_LAST   = 16'(DRAIN_TIMEOUT - 1);

    state_t                    state;
    state_t                    state_nx;
    logic [4:0]                rst_cnt;
    logic [15:0]               drain_cnt;
    logic [FFT_SIZE_WIDTH-1:0] req_q;
    logic [FFT_SIZE_WIDTH-1:0] pending;
    logic [FFT_SIZE_WIDTH-1:0] active_nx;
    logic [NFFT_WIDTH-1:0]     pending_nfft;
    logic [NFFT_WIDTH-1:0]     active_nfft;
    logic [NFFT_WIDTH-1:0]     active_nfft_nx;
    logic                      req_legal;
    logic                      req_illegal;
    logic [NFFT_WIDTH-1:0]     req_nfft;
    logic                      drain_last;
    logic                      drain_exit;

    // The request is registered once before decode, giving the two-edge gate latency.
    fft_size_decode #(
        .FFT_SIZE_WIDTH(FFT_SIZE_WIDTH)
    ) u_req_decode (
        .size   (req_q),
        .legal  (req_legal),
        .illegal(req_illegal),
        .nfft   (req_nfft)
    );

    assign drain_last = (drain_cnt == DRAIN_LAST);

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state           <= S_INIT;
            rst_cnt         <= RST_LOAD;
            drain_cnt       <= '0;
            req_q           <= '0;
            pending         <= DEFAULT_SIZE;
            pending_nfft    <= DEFAULT_DEC[NFFT_WIDTH-1:0];
            fft_size_active <= DEFAULT_SIZE;
            active_nfft     <= DEFAULT_DEC[NFFT_WIDTH-1:0];
            cfg_error       <= 1'b0;
            drain_timeout   <= 1'b0;
        end else begin
            state           <= state_nx;
            req_q           <= fft_size_req;
            fft_size_active <= active_nx;
            active_nfft     <= active_nfft_nx;
            rst_cnt         <= (state == S_INIT) ? rst_cnt - 5'd1 : RST_LOAD;
            drain_cnt       <= (state == S_DRAIN) ? drain_cnt + 16'd1 : '0;
            // Last legal request wins while draining; the drain itself is never restarted.
            if (((state == S_RUN) || (state == S_DRAIN)) && req_legal) begin
                pending      <= req_q;
                pending_nfft <= req_nfft;
            end
            if (req_illegal) begin
                cfg_error <= 1'b1;
            end
            if (drain_exit && !frame_done) begin
                drain_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx       = state;
        active_nx      = fft_size_active;
        active_nfft_nx = active_nfft;
        drain_exit     = 1'b0;
        case (state)
            S_INIT: begin
                if (rst_cnt == '0) state_nx = S_CONFIG;
            end
            S_CONFIG: begin
                if (fft_config_tready) state_nx = S_RUN;
            end
            S_RUN: begin
                if (req_legal && (req_q != fft_size_active)) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (frame_done || drain_last) begin
                    state_nx   = S_INIT;
                    drain_exit = 1'b1;
                    if (req_legal) begin
                        active_nx      = req_q;
                        active_nfft_nx = req_nfft;
                    end else begin
                        active_nx      = pending;
                        active_nfft_nx = pending_nfft;
                    end
                end
            end
            default: state_nx = S_INIT;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            chan_reset        <= 1'b1;
            fft_aresetn       <= 1'b0;
            gate_en           <= 1'b0;
            fft_config_tvalid <= 1'b0;
            busy              <= 1'b1;
            fft_config_tdata  <= {{(16 - NFFT_WIDTH){1'b0}}, DEFAULT_DEC[NFFT_WIDTH-1:0]};
        end else begin
            chan_reset        <= (state_nx == S_INIT) || (state_nx == S_CONFIG);
            fft_aresetn       <= (state_nx != S_INIT);
            gate_en           <= (state_nx == S_RUN);
            fft_config_tvalid <= (state_nx == S_CONFIG);
            busy              <= (state_nx != S_RUN);
            fft_config_tdata  <= {{(16 - NFFT_WIDTH){1'b0}}, active_nfft_nx};
        end
    end

endmodule

// File: tb/tb_chan_reconfig_ctrl.sv
// Self-checking bench for chan_reconfig_ctrl: request table, mid-drain and
// reset-in-config sequences, config beats checked against an expected queue.
module tb_chan_reconfig_ctrl;

    localparam int DRAIN_TO = 24;
    localparam int RST_CYC  = 8;

    logic        clk = 1'b0;
    logic        sync_reset;
    logic [11:0] fft_size_req;
    logic        frame_done;
    logic        gate_en;
    logic        chan_reset;
    logic        fft_aresetn;
    logic        fft_config_tvalid;
    logic [15:0] fft_config_tdata;
    logic        fft_config_tready;
    logic [11:0] fft_size_active;
    logic        busy;
    logic        cfg_error;
    logic        drain_timeout;

    int          n_cmp    = 0;
    int          n_err    = 0;
    int          beat_cnt = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [11:0] req;
        logic        reconf;
        int          fd;
        logic [15:0] exp_tdata;
        logic [11:0] exp_active;
        logic        exp_cfg;
        logic        exp_dto;
    } vec_t;

    always #5 clk = ~clk;

    chan_reconfig_ctrl #(
        .FFT_SIZE_WIDTH  (12),
        .DEFAULT_FFT_SIZE(128),
        .RESET_CYCLES    (RST_CYC),
        .DRAIN_TIMEOUT   (DRAIN_TO)
    ) dut (
        .clk              (clk),
        .sync_reset       (sync_reset),
        .fft_size_req     (fft_size_req),
        .frame_done       (frame_done),
        .gate_en          (gate_en),
        .chan_reset       (chan_reset),
        .fft_aresetn      (fft_aresetn),
        .fft_config_tvalid(fft_config_tvalid),
        .fft_config_tdata (fft_config_tdata),
        .fft_config_tready(fft_config_tready),
        .fft_size_active  (fft_size_active),
        .busy             (busy),
        .cfg_error        (cfg_error),
        .drain_timeout    (drain_timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted config beat must match the next expected tdata.
    always @(negedge clk) begin
        logic [15:0] e;
        if (fft_config_tvalid === 1'b1 && fft_config_tready === 1'b1) begin
            beat_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL cfg_beat: got 0x%04h expected no beat", fft_config_tdata);
            end else begin
                e = exp_q.pop_front();
                check("cfg_tdata", fft_config_tdata, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_run(output int len);
        len = 0;
        for (int i = 0; i < 200 && gate_en !== 1'b1; i++) begin
            if (fft_aresetn === 1'b0) len++;
            @(negedge clk);
        end
        n_cmp++;
        if (gate_en !== 1'b1) begin
            n_err++;
            $display("FAIL wait_run: gate_en got %b expected 1 within 200 cycles", gate_en);
        end
    endtask

    task automatic steady(input string name, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (gate_en !== 1'b1 || chan_reset !== 1'b0 || busy !== 1'b0 || fft_config_tvalid !== 1'b0)
                bad++;
        end
        check(name, bad, 0);
    endtask

    task automatic start_reconf(input logic [11:0] req);
        tick();
        fft_size_req = req;
        @(negedge clk);
        @(negedge clk);
        check("lat_edge1_gate", gate_en, 1);
        @(negedge clk);
        check("lat_edge2_gate", gate_en, 0);
    endtask

    // Called in drain cycle 0; returns the number of drain cycles observed.
    task automatic drain_phase(input int fd, input int chg, input logic [11:0] chg_req, output int len);
        len = 1;
        for (int cyc = 1; cyc < 200; cyc++) begin
            tick();
            frame_done = (cyc == fd);
            if (cyc == chg) fft_size_req = chg_req;
            @(negedge clk);
            if (chan_reset === 1'b1) break;
            len++;
        end
        frame_done = 1'b0;
    endtask

    task automatic mid_drain(input logic [11:0] first, input logic [11:0] second,
                             input logic [15:0] exp_tdata, input logic [11:0] exp_active);
        int b0, dl, rl;
        b0 = beat_cnt;
        exp_q.push_back(exp_tdata);
        start_reconf(first);
        drain_phase(8, 3, second, dl);
        check("mid_drain_len", dl, 9);
        wait_run(rl);
        check("mid_reset_len", rl, RST_CYC);
        check("mid_beats", beat_cnt - b0, 1);
        check("mid_active", fft_size_active, exp_active);
        steady("mid_steady", 12);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   dl, rl, exp_dl, b0;

        vecs[0] = '{req:12'd300,  reconf:1'b0, fd:0,          exp_tdata:16'h0000, exp_active:12'd128,  exp_cfg:1'b1, exp_dto:1'b0};
        vecs[1] = '{req:12'd512,  reconf:1'b1, fd:20,         exp_tdata:16'h0009, exp_active:12'd512,  exp_cfg:1'b1, exp_dto:1'b0};
        vecs[2] = '{req:12'd0,    reconf:1'b0, fd:0,          exp_tdata:16'h0000, exp_active:12'd512,  exp_cfg:1'b1, exp_dto:1'b0};
        vecs[3] = '{req:12'd2048, reconf:1'b1, fd:DRAIN_TO-1, exp_tdata:16'h000B, exp_active:12'd2048, exp_cfg:1'b1, exp_dto:1'b0};
        vecs[4] = '{req:12'd8,    reconf:1'b1, fd:1,          exp_tdata:16'h0003, exp_active:12'd8,    exp_cfg:1'b1, exp_dto:1'b0};
        vecs[5] = '{req:12'd8,    reconf:1'b0, fd:0,          exp_tdata:16'h0000, exp_active:12'd8,    exp_cfg:1'b1, exp_dto:1'b0};
        vecs[6] = '{req:12'd1024, reconf:1'b1, fd:0,          exp_tdata:16'h000A, exp_active:12'd1024, exp_cfg:1'b1, exp_dto:1'b1};
        vecs[7] = '{req:12'd2049, reconf:1'b0, fd:0,          exp_tdata:16'h0000, exp_active:12'd1024, exp_cfg:1'b1, exp_dto:1'b1};

        sync_reset        = 1'b1;
        fft_size_req      = 12'd0;
        frame_done        = 1'b0;
        fft_config_tready = 1'b1;
        exp_q.push_back(16'h0007);

        // Power-up reset and first configuration.
        tick();
        tick();
        @(negedge clk);
        check("rst_chan_reset", chan_reset, 1);
        check("rst_aresetn", fft_aresetn, 0);
        check("rst_gate", gate_en, 0);
        check("rst_tvalid", fft_config_tvalid, 0);
        check("rst_busy", busy, 1);
        check("rst_cfg_error", cfg_error, 0);
        check("rst_drain_timeout", drain_timeout, 0);
        check("rst_active", fft_size_active, 128);
        check("rst_tdata", fft_config_tdata, 16'h0007);
        tick();
        sync_reset = 1'b0;
        @(negedge clk);
        wait_run(rl);
        check("init_reset_len", rl, RST_CYC);
        check("init_beats", beat_cnt, 1);
        check("init_busy", busy, 0);
        check("init_chan_reset", chan_reset, 0);
        steady("init_steady", 4);

        for (int i = 0; i < 8; i++) begin
            b0 = beat_cnt;
            if (vecs[i].reconf) begin
                exp_q.push_back(vecs[i].exp_tdata);
                start_reconf(vecs[i].req);
                drain_phase(vecs[i].fd, -1, 12'd0, dl);
                exp_dl = (vecs[i].fd > 0 && vecs[i].fd < DRAIN_TO) ? vecs[i].fd + 1 : DRAIN_TO;
                check($sformatf("vec%0d_drain_len", i), dl, exp_dl);
                wait_run(rl);
                check($sformatf("vec%0d_reset_len", i), rl, RST_CYC);
                steady($sformatf("vec%0d_steady", i), 4);
            end else begin
                tick();
                fft_size_req = vecs[i].req;
                steady($sformatf("vec%0d_steady", i), 12);
            end
            check($sformatf("vec%0d_beats", i), beat_cnt - b0, vecs[i].reconf ? 1 : 0);
            check($sformatf("vec%0d_active", i), fft_size_active, vecs[i].exp_active);
            check($sformatf("vec%0d_cfg_error", i), cfg_error, vecs[i].exp_cfg);
            check($sformatf("vec%0d_drain_timeout", i), drain_timeout, vecs[i].exp_dto);
        end

        // Request replaced mid-drain, then replaced by the old active size.
        mid_drain(12'd256, 12'd64, 16'h0006, 12'd64);
        mid_drain(12'd512, 12'd64, 16'h0006, 12'd64);

        // Reset while stalled in config.
        tick();
        fft_config_tready = 1'b0;
        fft_size_req      = 12'd2048;
        for (int i = 0; i < 200 && fft_config_tvalid !== 1'b1; i++) @(negedge clk);
        check("stall_tvalid", fft_config_tvalid, 1);
        @(negedge clk);
        @(negedge clk);
        check("stall_tvalid_held", fft_config_tvalid, 1);
        check("stall_tdata", fft_config_tdata, 16'h000B);
        check("stall_aresetn", fft_aresetn, 1);
        check("stall_chan_reset", chan_reset, 1);
        tick();
        sync_reset   = 1'b1;
        fft_size_req = 12'd0;
        @(negedge clk);
        @(negedge clk);
        check("abort_chan_reset", chan_reset, 1);
        check("abort_aresetn", fft_aresetn, 0);
        check("abort_gate", gate_en, 0);
        check("abort_tvalid", fft_config_tvalid, 0);
        check("abort_busy", busy, 1);
        check("abort_cfg_error", cfg_error, 0);
        check("abort_drain_timeout", drain_timeout, 0);
        check("abort_active", fft_size_active, 128);
        check("abort_tdata", fft_config_tdata, 16'h0007);
        exp_q.delete();
        exp_q.push_back(16'h0007);
        tick();
        sync_reset        = 1'b0;
        fft_config_tready = 1'b1;
        @(negedge clk);
        wait_run(rl);
        check("abort_reset_len", rl, RST_CYC);
        steady("abort_steady", 6);

        check("exp_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
